// File: rtl/inst_fetch_pkg.sv
// Shared types and default widths for the instruction fetch unit.
package inst_fetch_pkg;

    localparam int unsigned PcWidthDef   = 16;
    localparam int unsigned InstWidthDef = 32;
    localparam int unsigned FifoDepthDef = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2
    } if_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction memory read bus plus fetch-to-decode handshake.
interface inst_fetch_if
    import inst_fetch_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = PcWidthDef,
    parameter int unsigned INST_WIDTH = InstWidthDef
);
    logic                  imem_rd;
    logic [PC_WIDTH-1:0]   imem_addr;
    logic [INST_WIDTH-1:0] imem_rdata;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [INST_WIDTH-1:0] inst_data;
    logic [PC_WIDTH-1:0]   inst_pc;

    modport master (
        output imem_rd, imem_addr, inst_valid, inst_data, inst_pc,
        input  imem_rdata, inst_ready
    );

    modport slave (
        input  imem_rd, imem_addr, inst_valid, inst_data, inst_pc,
        output imem_rdata, inst_ready
    );

endinterface

// File: rtl/inst_fetch_fifo.sv
// Synchronous FIFO for fetched {instruction, pc} entries; flush empties it in one cycle.
module inst_fetch_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Fetch unit: owns the fetch PC, issues credit-limited reads, buffers returns for decode.
// Define IFETCH_PERF_EN to add the perf_fetched / perf_stall counters.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned PC_WIDTH   = PcWidthDef,
    parameter int unsigned INST_WIDTH = InstWidthDef,
    parameter int unsigned FIFO_DEPTH = FifoDepthDef
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                redir_valid,
    input  logic [PC_WIDTH-1:0] redir_pc,
    inst_fetch_if.master        bus
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_stall
`endif
);
    localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned EntryW = INST_WIDTH + PC_WIDTH;

    if_state_e           state_q, state_d;
    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic                inflight_q, inflight_d;
    logic                issue, credit_ok, inst_valid, pop;
    logic [CntW-1:0]     fifo_count;
    logic                fifo_full, fifo_empty;
    logic [EntryW-1:0]   fifo_rdata;

    // Credit counts the buffered entries plus the read whose data is still on its way.
    assign credit_ok = !fifo_full && ((32'(fifo_count) + 32'(inflight_q)) < FIFO_DEPTH);

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        issue         = 1'b0;
        unique case (state_q)
            StIdle:  if (en) state_d = StRun;
            StRun: begin
                issue = credit_ok;
                if (!en) state_d = StIdle;
            end
            StFlush: state_d = en ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
        if (issue) begin
            fetch_pc_d    = fetch_pc_q + 1'b1;
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
        end
        // Redirect kills a read issued this cycle by never marking it in flight.
        if (redir_valid) begin
            state_d    = StFlush;
            fetch_pc_d = redir_pc;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            fetch_pc_q    <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    inst_fetch_fifo #(
        .WIDTH (EntryW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight_q),
        .pop   (pop),
        .flush (redir_valid),
        .wdata ({bus.imem_rdata, inflight_pc_q}),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign inst_valid    = !fifo_empty;
    assign pop           = inst_valid && bus.inst_ready;
    assign bus.imem_rd   = issue;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.inst_valid = inst_valid;

    always_comb begin
        bus.inst_data = '0;
        bus.inst_pc   = '0;
        if (inst_valid) begin
            bus.inst_data = fifo_rdata[EntryW-1:PC_WIDTH];
            bus.inst_pc   = fifo_rdata[PC_WIDTH-1:0];
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d, perf_stall_q, perf_stall_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stall_d   = perf_stall_q;
        if (pop && (perf_fetched_q != '1)) perf_fetched_d = perf_fetched_q + 1'b1;
        if (inst_valid && !bus.inst_ready && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus a random run, with a stream scoreboard.
module tb_inst_fetch;
    localparam int unsigned PW    = 16;
    localparam int unsigned IW    = 32;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          redir_valid = 1'b0;
    logic [PW-1:0] redir_pc = '0;
    int            checks = 0;
    int            errors = 0;

    inst_fetch_if #(.PC_WIDTH(PW), .INST_WIDTH(IW)) bus ();

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall;
`endif

    inst_fetch #(
        .PC_WIDTH   (PW),
        .INST_WIDTH (IW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .redir_valid  (redir_valid),
        .redir_pc     (redir_pc),
        .bus          (bus)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
        return IW'(a) << 2;
    endfunction

    // Instruction memory: one-cycle read latency, random junk when not read.
    always @(posedge clk) begin
        if (bus.imem_rd) bus.imem_rdata <= mem_word(bus.imem_addr);
        else             bus.imem_rdata <= $urandom;
    end

    // Scoreboard: accepted instructions form a consecutive PC run from the last reset/redirect.
    logic [PW-1:0] exp_issue, exp_pop, outstanding;
    bit            seen_rst = 1'b0;
    bit            quiet_chk = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            seen_rst  = 1'b1;
            exp_issue = '0;
            exp_pop   = '0;
            quiet_chk = 1'b1;
        end else if (seen_rst) begin
            if (quiet_chk) begin
                checks++;
                if (bus.imem_rd !== 1'b0 || bus.inst_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL quiet_after_event: imem_rd=%b inst_valid=%b, required 0/0",
                             bus.imem_rd, bus.inst_valid);
                end
            end
            outstanding = exp_issue - exp_pop;
            checks++;
            if (outstanding > PW'(DEPTH)) begin
                errors++;
                $display("FAIL outstanding: %0d reads unconsumed, required <= %0d",
                         outstanding, DEPTH);
            end
            if (bus.imem_rd === 1'b1) begin
                checks++;
                if (bus.imem_addr !== exp_issue) begin
                    errors++;
                    $display("FAIL issue_addr: got %h, required %h", bus.imem_addr, exp_issue);
                end
                exp_issue = exp_issue + 1'b1;
            end
            if (bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) begin
                checks++;
                if (bus.inst_pc !== exp_pop || bus.inst_data !== mem_word(exp_pop)) begin
                    errors++;
                    $display("FAIL pop_stream: got pc=%h data=%h, required pc=%h data=%h",
                             bus.inst_pc, bus.inst_data, exp_pop, mem_word(exp_pop));
                end
                exp_pop = exp_pop + 1'b1;
            end
            quiet_chk = redir_valid;
            if (redir_valid) begin
                exp_issue = redir_pc;
                exp_pop   = redir_pc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        en = 1'b0;
        bus.inst_ready = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b0;
        redir_valid = 1'b0;
        bus.inst_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (bus.imem_rd !== 1'b0 || bus.imem_addr !== '0 || bus.inst_valid !== 1'b0 ||
            bus.inst_data !== '0 || bus.inst_pc !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rd=%b addr=%h valid=%b data=%h pc=%h, required all 0",
                     bus.imem_rd, bus.imem_addr, bus.inst_valid, bus.inst_data, bus.inst_pc);
        end
`ifdef IFETCH_PERF_EN
        checks++;
        if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset: fetched=%0d stall=%0d, required 0/0",
                     perf_fetched, perf_stall);
        end
`endif
    endtask

    task automatic test_stream();
        bus.inst_ready = 1'b1;
        en = 1'b1;
        tick();
        checks++;
        if (bus.imem_rd !== 1'b1 || bus.imem_addr !== '0) begin
            errors++;
            $display("FAIL first_issue: rd=%b addr=%h, required 1/0", bus.imem_rd, bus.imem_addr);
        end
        tick();
        checks++;
        if (bus.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_gap: inst_valid=%b, required 0", bus.inst_valid);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== PW'(i) ||
                bus.inst_data !== mem_word(PW'(i))) begin
                errors++;
                $display("FAIL back_to_back[%0d]: valid=%b pc=%h data=%h, required 1/%h/%h",
                         i, bus.inst_valid, bus.inst_pc, bus.inst_data, i, mem_word(PW'(i)));
            end
        end
        drain();
    endtask

    task automatic test_backpressure();
        int n = 0;
        do_reset();
        bus.inst_ready = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.imem_rd === 1'b1) n++;
        end
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL issue_count_full: %0d issues, required %0d", n, DEPTH);
        end
        checks++;
        if (bus.imem_rd !== 1'b0 || bus.inst_valid !== 1'b1 || bus.inst_pc !== '0) begin
            errors++;
            $display("FAIL full_hold: rd=%b valid=%b pc=%h, required 0/1/0",
                     bus.imem_rd, bus.inst_valid, bus.inst_pc);
        end
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (bus.inst_valid !== 1'b1 || bus.inst_pc !== PW'(i)) begin
                errors++;
                $display("FAIL drain_order[%0d]: valid=%b pc=%h, required 1/%h",
                         i, bus.inst_valid, bus.inst_pc, i);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_redirect();
        bit found = 1'b0;
        do_reset();
        bus.inst_ready = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (bus.imem_rd === 1'b1 && bus.imem_addr === PW'(7)) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL find_pc7: issue of pc 7 not seen within 30 cycles, required seen");
        end
        tick();
        redir_valid = 1'b1;
        redir_pc = PW'(16'h0040);
        tick();
        redir_valid = 1'b0;
        checks++;
        if (bus.imem_rd !== 1'b0 || bus.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle: rd=%b valid=%b, required 0/0",
                     bus.imem_rd, bus.inst_valid);
        end
        tick();
        checks++;
        if (bus.imem_rd !== 1'b1 || bus.imem_addr !== PW'(16'h0040)) begin
            errors++;
            $display("FAIL redir_issue: rd=%b addr=%h, required 1/0040",
                     bus.imem_rd, bus.imem_addr);
        end
        tick();
        tick();
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== PW'(16'h0040) ||
            bus.inst_data !== mem_word(PW'(16'h0040))) begin
            errors++;
            $display("FAIL redir_first: valid=%b pc=%h data=%h, required 1/0040/%h",
                     bus.inst_valid, bus.inst_pc, bus.inst_data, mem_word(PW'(16'h0040)));
        end
        drain();
    endtask

    task automatic test_wrap();
        logic [PW-1:0] got_pc [4];
        logic [PW-1:0] exp_pc [4];
        int got = 0;
        exp_pc[0] = PW'(16'hFFFE);
        exp_pc[1] = PW'(16'hFFFF);
        exp_pc[2] = PW'(16'h0000);
        exp_pc[3] = PW'(16'h0001);
        do_reset();
        bus.inst_ready = 1'b1;
        en = 1'b1;
        redir_valid = 1'b1;
        redir_pc = PW'(16'hFFFE);
        tick();
        redir_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.inst_valid === 1'b1 && got < 4) begin
                got_pc[got] = bus.inst_pc;
                got++;
            end
        end
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL wrap_count: %0d instructions, required 4", got);
        end
        for (int k = 0; k < got; k++) begin
            checks++;
            if (got_pc[k] !== exp_pc[k]) begin
                errors++;
                $display("FAIL wrap_seq[%0d]: pc=%h, required %h", k, got_pc[k], exp_pc[k]);
            end
        end
        drain();
    endtask

    task automatic test_rst_mid();
        do_reset();
        bus.inst_ready = 1'b0;
        en = 1'b1;
        repeat (5) tick();
        checks++;
        if (bus.inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_rst_valid: inst_valid=%b, required 1", bus.inst_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.imem_rd !== 1'b0 || bus.imem_addr !== '0) begin
            errors++;
            $display("FAIL rst_mid_quiet: valid=%b rd=%b addr=%h, required 0/0/0",
                     bus.inst_valid, bus.imem_rd, bus.imem_addr);
        end
        tick();
        checks++;
        if (bus.imem_rd !== 1'b1 || bus.imem_addr !== '0) begin
            errors++;
            $display("FAIL restart_at_0: rd=%b addr=%h, required 1/0", bus.imem_rd, bus.imem_addr);
        end
        bus.inst_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== '0 || bus.inst_data !== '0) begin
            errors++;
            $display("FAIL restart_first: valid=%b pc=%h data=%h, required 1/0/0",
                     bus.inst_valid, bus.inst_pc, bus.inst_data);
        end
        drain();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            en             = ($urandom_range(0, 9) != 0);
            bus.inst_ready = ($urandom_range(0, 3) != 0);
            redir_valid    = ($urandom_range(0, 24) == 0);
            redir_pc       = ($urandom_range(0, 3) == 0) ? PW'(16'hFFFC + $urandom_range(0, 3))
                                                         : PW'($urandom);
            rst            = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        redir_valid = 1'b0;
        drain();
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.imem_rd !== 1'b0) begin
            errors++;
            $display("FAIL random_drain: valid=%b rd=%b, required 0/0",
                     bus.inst_valid, bus.imem_rd);
        end
    endtask

`ifdef IFETCH_PERF_EN
    task automatic test_perf();
        do_reset();
        checks++;
        if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin
            errors++;
            $display("FAIL perf_after_rst: fetched=%0d stall=%0d, required 0/0",
                     perf_fetched, perf_stall);
        end
        bus.inst_ready = 1'b1;
        en = 1'b1;
        repeat (5) tick();
        en = 1'b0;
        bus.inst_ready = 1'b0;
        repeat (3) tick();
        bus.inst_ready = 1'b1;
        repeat (5) tick();
        checks++;
        if (perf_fetched !== 32'd5 || perf_stall !== 32'd3) begin
            errors++;
            $display("FAIL perf_counts: fetched=%0d stall=%0d, required 5/3",
                     perf_fetched, perf_stall);
        end
        drain();
    endtask
`endif

    initial begin
        bus.inst_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_rst_mid();
`ifdef IFETCH_PERF_EN
        test_perf();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
